dense_layer_stream: RTL and testbench

Parametrised, time-multiplexed fully-connected layer for the digit-recognition datapath. It consumes one input activation per cycle over a valid/ready stream, fetches the matching weight row from an external registered ROM, and accumulates all `N_OUT` neurons in parallel. At end of frame it adds biases, rescales, saturates, optionally applies ReLU, then runs a sequential argmax. It replaces the fixed hidden/output layer plus combinational argmax, and is instantiated once per layer.

---
 rtl/nn_pkg.sv | 30 +++
 rtl/dense_layer_stream_if.sv | 33 +++
 rtl/argmax_scan.sv | 57 +++++
 rtl/dense_layer_stream.sv | 163 ++++++++++++++++
 tb/tb_dense_layer_stream.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed dense layer.
// Holds the FSM state enum, index width helper and saturation.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_FINAL,
        ST_SCAN,
        ST_OUT
    } dl_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/dense_layer_stream_if.sv
// Activation input stream and result output stream of one layer.
// slave is the layer's view, master the producer/consumer view.
interface dense_layer_stream_if #(
    parameter int DATA_W = 16,
    parameter int N_OUT  = 10
);
    import nn_pkg::*;

    localparam int AW = idx_w(N_OUT);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [AW-1:0]           out_argmax;
    logic                    out_len_err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data,
        output out_argmax, out_len_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_argmax, out_len_err
    );

endinterface

// File: rtl/argmax_scan.sv
// Sequential argmax over the registered neuron results.
// One element per step; ties keep the lowest index.
module argmax_scan
    import nn_pkg::*;
#(
    parameter  int N_OUT  = 10,
    parameter  int DATA_W = 16,
    localparam int AW     = idx_w(N_OUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    step_i,
    input  logic [DATA_W-1:0]       first_i,
    input  logic [N_OUT*DATA_W-1:0] vals_i,
    output logic                    done_o,
    output logic [AW-1:0]           best_o
);

    logic [AW-1:0]            sidx_q;
    logic [AW-1:0]            best_q;
    logic signed [DATA_W-1:0] best_val_q;
    logic signed [DATA_W-1:0] cur;

    // select the element under the scan index
    always_comb begin
        cur = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (sidx_q == AW'(k)) begin
                cur = $signed(vals_i[k*DATA_W +: DATA_W]);
            end
        end
    end

    assign done_o = (sidx_q == AW'(N_OUT - 1));
    assign best_o = best_q;

    // running best index/value and scan position
    always_ff @(posedge clk) begin
        if (reset) begin
            sidx_q     <= '0;
            best_q     <= '0;
            best_val_q <= '0;
        end else if (start_i) begin
            sidx_q     <= AW'(1);
            best_q     <= '0;
            best_val_q <= $signed(first_i);
        end else if (step_i) begin
            if (cur > best_val_q) begin
                best_q     <= sidx_q;
                best_val_q <= cur;
            end
            sidx_q <= sidx_q + AW'(1);
        end
    end

endmodule

// File: rtl/dense_layer_stream.sv
// Time-multiplexed fully-connected layer with streamed activations.
// All neurons accumulate in parallel; argmax runs after the frame.
module dense_layer_stream
    import nn_pkg::*;
#(
    parameter  int N_IN    = 784,
    parameter  int N_OUT   = 10,
    parameter  int DATA_W  = 16,
    parameter  int FRAC_W  = 8,
    parameter  int ACC_W   = 40,
    parameter  int RELU_EN = 1,
    localparam int IW      = idx_w(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    dense_layer_stream_if.slave     strm,
    output logic [IW-1:0]           w_addr,
    input  logic [N_OUT*DATA_W-1:0] w_data,
    input  logic [N_OUT*DATA_W-1:0] bias
);

    localparam int AW = idx_w(N_OUT);
    localparam int PW = 2 * DATA_W;

    if (ACC_W < 2 * DATA_W + $clog2(N_IN)) begin : g_acc_chk
        $error("ACC_W too narrow for DATA_W and N_IN");
    end

    dl_state_t                state_q;
    dl_state_t                state_d;
    logic [IW-1:0]            idx_q;
    logic signed [DATA_W-1:0] x_q;
    logic                     mac_q;
    logic                     len_err_q;
    logic signed [ACC_W-1:0]  acc_q [N_OUT];
    logic signed [PW-1:0]     prod [N_OUT];
    logic [N_OUT*DATA_W-1:0]  out_data_q;
    logic [N_OUT*DATA_W-1:0]  res_d;
    logic signed [ACC_W-1:0]  fin_sum;
    logic signed [63:0]       fin_sat;
    logic signed [DATA_W-1:0] fin_r;
    logic                     accept;
    logic                     is_end;
    logic                     frame_end;
    logic                     out_hs;
    logic                     scan_start;
    logic                     scan_step;
    logic                     scan_done;
    logic [AW-1:0]            best;

    assign accept     = (state_q == ST_ACCUM) && strm.in_valid;
    assign is_end     = (idx_q == IW'(N_IN - 1));
    assign frame_end  = accept && (strm.in_last || is_end);
    assign out_hs     = (state_q == ST_OUT) && strm.out_ready;
    assign scan_start = (state_q == ST_FINAL);
    assign scan_step  = (state_q == ST_SCAN);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_ACCUM;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM: if (frame_end) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_FINAL;
            ST_FINAL: state_d = (N_OUT > 1) ? ST_SCAN : ST_OUT;
            ST_SCAN:  if (scan_done) state_d = ST_OUT;
            ST_OUT:   if (strm.out_ready) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    // handshake outputs decoded from the state register
    always_comb begin
        strm.in_ready  = (state_q == ST_ACCUM);
        strm.out_valid = (state_q == ST_OUT);
    end

    assign w_addr           = idx_q;
    assign strm.out_data    = out_data_q;
    assign strm.out_argmax  = best;
    assign strm.out_len_err = len_err_q;

    // element counter, operand latch and length-error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            x_q       <= '0;
            mac_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            mac_q <= accept;
            if (accept) begin
                x_q   <= $signed(strm.in_data);
                idx_q <= idx_q + IW'(1);
            end
            if (frame_end) len_err_q <= strm.in_last ^ is_end;
            if (out_hs) begin
                idx_q     <= '0;
                len_err_q <= 1'b0;
            end
        end
    end

    // full-width products against the row fetched last cycle
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            prod[j] = PW'(x_q)
                    * PW'($signed(w_data[j*DATA_W +: DATA_W]));
        end
    end

    // per-neuron accumulators, wrapping at ACC_W
    always_ff @(posedge clk) begin
        for (int j = 0; j < N_OUT; j++) begin
            if (reset || out_hs) acc_q[j] <= '0;
            else if (mac_q)      acc_q[j] <= acc_q[j] + ACC_W'(prod[j]);
        end
    end

    // bias, rescale, saturate and optional ReLU
    always_comb begin
        res_d   = '0;
        fin_sum = '0;
        fin_sat = '0;
        fin_r   = '0;
        for (int j = 0; j < N_OUT; j++) begin
            fin_sum = acc_q[j]
                    + (ACC_W'($signed(bias[j*DATA_W +: DATA_W]))
                       <<< FRAC_W);
            fin_sum = fin_sum >>> FRAC_W;
            fin_sat = sat_signed(64'(fin_sum), DATA_W);
            fin_r   = DATA_W'(fin_sat);
            if (RELU_EN != 0 && fin_r[DATA_W-1]) fin_r = '0;
            res_d[j*DATA_W +: DATA_W] = fin_r;
        end
    end

    // result register, loaded once per frame
    always_ff @(posedge clk) begin
        if (reset)         out_data_q <= '0;
        else if (scan_start) out_data_q <= res_d;
    end

    argmax_scan #(
        .N_OUT  (N_OUT),
        .DATA_W (DATA_W)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .start_i (scan_start),
        .step_i  (scan_step),
        .first_i (res_d[DATA_W-1:0]),
        .vals_i  (out_data_q),
        .done_o  (scan_done),
        .best_o  (best)
    );

endmodule

// File: tb/tb_dense_layer_stream.sv
// Bench for dense_layer_stream: two configurations, scoreboarded.
// Expected results come from an integer model of the layer.
module tb_dense_layer_stream;
    import nn_pkg::*;

    typedef struct packed {
        logic [23:0] data;
        logic [1:0]  arg;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  wa_addr;
    logic [0:0]  wb_addr;
    logic [23:0] wd_a, wd_b, bias_a, bias_b;
    logic [23:0] rom_a [4];
    logic [23:0] rom_b [2];

    int xs [4];
    int wa [4][3];
    int ba [3];
    int wb [3];
    int bb [3];

    exp_t qa [$];
    exp_t qb [$];
    exp_t ea, eb;
    int   n_chk = 0;
    int   n_pass = 0;

    dense_layer_stream_if #(.DATA_W(8), .N_OUT(3)) sa ();
    dense_layer_stream_if #(.DATA_W(8), .N_OUT(3)) sb ();

    dense_layer_stream #(
        .N_IN(4), .N_OUT(3), .DATA_W(8),
        .FRAC_W(0), .ACC_W(20), .RELU_EN(1)
    ) dut_a (
        .clk(clk), .reset(reset), .strm(sa),
        .w_addr(wa_addr), .w_data(wd_a), .bias(bias_a)
    );

    dense_layer_stream #(
        .N_IN(1), .N_OUT(3), .DATA_W(8),
        .FRAC_W(4), .ACC_W(20), .RELU_EN(0)
    ) dut_b (
        .clk(clk), .reset(reset), .strm(sb),
        .w_addr(wb_addr), .w_data(wd_b), .bias(bias_b)
    );

    assign bias_a = {ba[2][7:0], ba[1][7:0], ba[0][7:0]};
    assign bias_b = {bb[2][7:0], bb[1][7:0], bb[0][7:0]};

    always @(posedge clk) begin
        wd_a <= rom_a[wa_addr];
        wd_b <= rom_b[wb_addr];
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic load_roms();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                rom_a[i][j*8 +: 8] = 8'(wa[i][j]);
        for (int j = 0; j < 3; j++) rom_b[0][j*8 +: 8] = 8'(wb[j]);
        rom_b[1] = '0;
    endtask

    function automatic exp_t model(input bit use_b, input int nt,
                                   input bit err);
        exp_t   e;
        longint acc;
        longint r [3];
        int     frac;
        int     best;
        frac   = use_b ? 4 : 0;
        e.data = '0;
        e.err  = err;
        for (int j = 0; j < 3; j++) begin
            acc = 0;
            for (int i = 0; i < nt; i++)
                acc += longint'(xs[i]) * (use_b ? wb[j] : wa[i][j]);
            acc += longint'(use_b ? bb[j] : ba[j])
                 * (longint'(1) << frac);
            r[j] = acc >>> frac;
            if (r[j] > 127)  r[j] = 127;
            if (r[j] < -128) r[j] = -128;
            if (!use_b && r[j] < 0) r[j] = 0;
            e.data[j*8 +: 8] = r[j][7:0];
        end
        best = 0;
        for (int j = 1; j < 3; j++) if (r[j] > r[best]) best = j;
        e.arg = 2'(best);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && sa.out_valid && sa.out_ready) begin
            if (qa.size() == 0) check("spurA", 1, 0);
            else begin
                ea = qa.pop_front();
                check("dataA", sa.out_data, ea.data);
                check("argA", sa.out_argmax, ea.arg);
                check("errA", sa.out_len_err, ea.err);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && sb.out_valid && sb.out_ready) begin
            if (qb.size() == 0) check("spurB", 1, 0);
            else begin
                eb = qb.pop_front();
                check("dataB", sb.out_data, eb.data);
                check("argB", sb.out_argmax, eb.arg);
                check("errB", sb.out_len_err, eb.err);
            end
        end
    end

    task automatic send_a(input int x, input bit last);
        bit ok;
        ok = 1'b0;
        sa.in_valid = 1'b1;
        sa.in_data  = 8'(x);
        sa.in_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = sa.in_ready;
            @(posedge clk);
            #1;
        end
        sa.in_valid = 1'b0;
        sa.in_last  = 1'b0;
        if (!ok) check("acceptA", 0, 1);
    endtask

    task automatic frame_a(input int n, input int lastpos,
                           input bit drain);
        int lat;
        qa.push_back(model(1'b0, n, lastpos != 3));
        for (int i = 0; i < n; i++) send_a(xs[i], i == lastpos);
        check("rdy_lowA", sa.in_ready, 0);
        lat = 1;
        while (!sa.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latA", lat, 5);
        if (drain) begin
            for (int k = 0; k < 10 && qa.size() != 0; k++) begin
                @(posedge clk);
                #1;
            end
            check("drainA", qa.size(), 0);
        end
    endtask

    task automatic frame_b(input int x, input bit last);
        bit ok;
        int lat;
        ok    = 1'b0;
        xs[0] = x;
        qb.push_back(model(1'b1, 1, !last));
        sb.in_valid = 1'b1;
        sb.in_data  = 8'(x);
        sb.in_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = sb.in_ready;
            @(posedge clk);
            #1;
        end
        sb.in_valid = 1'b0;
        sb.in_last  = 1'b0;
        if (!ok) check("acceptB", 0, 1);
        lat = 1;
        while (!sb.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latB", lat, 5);
        for (int k = 0; k < 10 && qb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drainB", qb.size(), 0);
    endtask

    task automatic chk_reset();
        check("rst_rdyA", sa.in_ready, 1);
        check("rst_vldA", sa.out_valid, 0);
        check("rst_dataA", sa.out_data, 0);
        check("rst_argA", sa.out_argmax, 0);
        check("rst_errA", sa.out_len_err, 0);
        check("rst_addrA", wa_addr, 0);
        check("rst_rdyB", sb.in_ready, 1);
        check("rst_vldB", sb.out_valid, 0);
    endtask

    task automatic set_wa(input int w0, input int w1, input int w2);
        for (int i = 0; i < 4; i++) begin
            wa[i][0] = w0;
            wa[i][1] = w1;
            wa[i][2] = w2;
        end
        load_roms();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t dropped;
        int   n;
        reset = 1'b1;
        sa.in_valid = 1'b0; sa.in_data = '0;
        sa.in_last = 1'b0;  sa.out_ready = 1'b1;
        sb.in_valid = 1'b0; sb.in_data = '0;
        sb.in_last = 1'b0;  sb.out_ready = 1'b1;
        ba = '{0, 0, 0};
        wb = '{32, -127, -127};
        bb = '{8, 0, -10};
        xs = '{1, 2, 3, 4};
        set_wa(1, 2, -1);
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        reset = 1'b0;

        // basic frame: expect {10, 20, 0}, argmax 1
        frame_a(4, 3, 1'b1);

        // saturation with a three-way tie
        xs = '{127, 127, 127, 127};
        set_wa(127, 127, 127);
        frame_a(4, 3, 1'b1);

        // early last, then a normal frame, then missing last
        xs = '{1, 2, 3, 4};
        set_wa(1, 1, 1);
        frame_a(2, 1, 1'b1);
        frame_a(4, 3, 1'b1);
        frame_a(4, -1, 1'b1);

        // back-pressure for five cycles
        set_wa(1, 2, -1);
        sa.out_ready = 1'b0;
        frame_a(4, 3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_vld", sa.out_valid, 1);
            check("bp_data", sa.out_data, qa[0].data);
            check("bp_arg", sa.out_argmax, qa[0].arg);
            check("bp_rdy", sa.in_ready, 0);
        end
        sa.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel", sa.in_ready, 1);
        check("bp_pop", qa.size(), 0);

        // reset mid-frame, then a clean frame
        send_a(5, 1'b0);
        send_a(6, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset();
        reset = 1'b0;
        frame_a(4, 3, 1'b1);

        // reset while holding a result
        sa.out_ready = 1'b0;
        frame_a(4, 3, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset();
        reset = 1'b0;
        dropped = qa.pop_front();
        sa.out_ready = 1'b1;

        // random frames, small values
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = int'($urandom_range(60)) - 30;
                for (int j = 0; j < 3; j++)
                    wa[i][j] = int'($urandom_range(40)) - 20;
            end
            load_roms();
            n = int'($urandom_range(1, 4));
            if (r == 5) frame_a(4, -1, 1'b1);
            else        frame_a(n, n - 1, 1'b1);
        end

        // fixed-point bias/scale, floor and saturation without ReLU
        frame_b(16, 1'b1);
        frame_b(-1, 1'b1);
        frame_b(127, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
